instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Parametrised instruction-fetch front end that replaces hand-driven instruction words into the DataPath with a self-sequencing fetch path. Holds a program counter, issues word reads to a synchronous instruction memory, and buffers returned words in a small prefetch queue. Presents one instruction per cycle to the DataPath under a valid/ready handshake and supports PC redirect with flush for branches and jumps.

## Interface
- XLEN, 32, instruction/PC width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- IMEM_AW, 8, instruction memory word-address width
- RESET_PC, 32'h0, PC loaded on reset

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  IMEM_AW  word address (pc[IMEM_AW+1:2])
- imem_rdata  in  XLEN  read data, valid exactly one cycle after imem_req
- redirect_valid  in  1  load new PC and flush this cycle
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored (forced 0)
- instr_valid  out  1  head of queue valid
- instr_word  out  XLEN  head instruction; NOP (32'h00000013) when invalid
- instr_pc  out  XLEN  PC of head instruction; 0 when invalid
- instr_ready  in  1  DataPath accepts head this cycle

## Operation
- Fetch: imem_req=1 when count + inflight < DEPTH and no redirect; pc advances by 4 each issued request, wraps modulo 2^XLEN.
- inflight: 1-bit flag set on request, cleared on return; return pushes {pc_of_req, imem_rdata} into queue.
- Pop on instr_valid && instr_ready. Simultaneous push and pop: count unchanged, order preserved.
- Full: count==DEPTH never occurs with request outstanding; push into full queue impossible by credit rule (assert in sim).
- Empty: instr_valid=0, instr_word=NOP, instr_pc=0.
- Redirect (highest priority): handshake in the same cycle still consumes head; then queue flushed, inflight return discarded (squash flag), pc <= {redirect_pc[XLEN-1:2],2'b00}; no imem_req that cycle.
- Back-to-back redirects: last one wins; each flushes.
- Reset mid-operation: all state cleared immediately (async), any memory return after reset discarded.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC[IMEM_AW+1:2], instr_valid=0, instr_word=32'h00000013, instr_pc=0, count=0, inflight=0.
- First request in first cycle after rst deasserts (cycle 0); data returns cycle 1.
- Fetch-to-issue latency: 2 cycles (request cycle 0, visible at instr_valid cycle 2) without bypass.
- Redirect at cycle N: request to new PC at N+1, instruction valid at N+3.
- Steady state with instr_ready=1: one instruction per cycle, no bubbles.
- All outputs registered except instr_valid/instr_word/instr_pc under bypass.

## Configuration
- IFQ_BYPASS_EN defined: when queue empty and a non-squashed return arrives, word is presented combinationally in the return cycle (latency 1); if accepted it is not written to the queue.
- Undefined: all returns go through the queue; latency 2; outputs purely registered.

## Structure
- Package rv_fetch_pkg: XLEN default, NOP_INSTR = 32'h00000013, fetch entry struct {pc, word}.
- Sub-module ifq_fifo: parametrised DEPTH circular buffer with rd/wr pointers, count, flush input; top holds PC, inflight/squash logic, bypass mux.

## Test plan
- Reset release, memory holding addi at words 0..7, instr_ready=1 -> instr_valid at cycle 2, instr_pc 0,4,8,... one per cycle, words match memory.
- instr_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered, imem_req drops to 0; ready=1 -> 4 words drain in order then stream continues, no duplicates/gaps.
- redirect_valid with redirect_pc=32'h40 while queue holds 3 and one inflight -> none of those issued afterwards; next instr_pc=0x40 three cycles later.
- redirect_pc=32'h43 -> fetch address word 0x10, instr_pc=0x40.
- rst asserted mid-stream with request outstanding -> outputs return to reset values same cycle; after release stream restarts at RESET_PC.
- With IFQ_BYPASS_EN: empty queue, ready=1 -> instr_valid in cycle 1 after reset release, instr_pc=0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue: default width,
// the canonical NOP encoding and the {pc, word} prefetch entry.
package rv_fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam logic [DEFAULT_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] word;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned, so the low two PC bits are always dropped.
    function automatic logic [DEFAULT_XLEN-1:0] align_pc(input logic [DEFAULT_XLEN-1:0] pc);
        return pc & {{(DEFAULT_XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular prefetch buffer of {pc, word} entries with read/write pointers,
// occupancy count and a single-cycle flush.
module ifq_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    // Pointers and occupancy; flush wins over any same-cycle read or write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr <= {PW{1'b0}};
            rd_ptr <= {PW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    // Entry storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == {CW{1'b0}});

    ifq_fifo_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .wr    (wr),
        .rd    (rd),
        .count (count)
    );

endmodule

// File: rtl/ifq_fifo_chk.sv
// Simulation checker for the prefetch buffer: the fetch credit rule must make
// overflow and underflow impossible.
module ifq_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    input logic          wr,
    input logic          rd,
    input logic [CW-1:0] count
);

    property p_no_overflow;
        @(posedge clk) disable iff (rst) !(wr && !rd && !flush && (count == CW'(DEPTH)));
    endproperty

    property p_no_underflow;
        @(posedge clk) disable iff (rst) !(rd && (count == {CW{1'b0}}));
    endproperty

    a_no_overflow:  assert property (p_no_overflow);
    a_no_underflow: assert property (p_no_underflow);

endmodule

// File: rtl/instr_fetch_queue.sv
// Self-sequencing instruction fetch front end: PC, one-deep memory request
// tracking with squash, prefetch queue and redirect. Optional IFQ_BYPASS_EN.
module instr_fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter int              IMEM_AW  = 8,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [XLEN-1:0]    instr_word,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] ret_pc_r;
    logic            req_r;
    logic            inflight_r;
    logic            squash_r;

    logic [CW-1:0]   q_count;
    logic [CW-1:0]   count_next;
    logic [CW:0]     credit_sum;
    logic            credit_ok;
    logic            q_empty;
    logic            ret_ok;
    logic            bypass;
    logic            pop;
    logic            q_rd;
    logic            q_wr;
    fetch_entry_t    head;
    fetch_entry_t    ret_entry;

    assign imem_req  = req_r;
    assign imem_addr = pc_r[IMEM_AW+1:2];
    assign ret_ok    = inflight_r & ~squash_r;
    assign ret_entry = '{pc: ret_pc_r, word: imem_rdata};

`ifdef IFQ_BYPASS_EN
    assign bypass = q_empty & ret_ok;
`else
    assign bypass = 1'b0;
`endif

    // Head presentation: a bypassed return beats the (empty) queue.
    always_comb begin
        instr_valid = 1'b0;
        instr_word  = NOP_INSTR;
        instr_pc    = {XLEN{1'b0}};
        if (bypass) begin
            instr_valid = 1'b1;
            instr_word  = imem_rdata;
            instr_pc    = ret_pc_r;
        end else if (!q_empty) begin
            instr_valid = 1'b1;
            instr_word  = head.word;
            instr_pc    = head.pc;
        end else begin
            instr_valid = 1'b0;
        end
    end

    assign pop  = instr_valid & instr_ready;
    assign q_rd = pop & ~q_empty;
    assign q_wr = ret_ok & ~redirect_valid & ~(bypass & instr_ready);

    // Occupancy after this edge, used to decide next cycle's request.
    always_comb begin
        count_next = {CW{1'b0}};
        if (redirect_valid) begin
            count_next = {CW{1'b0}};
        end else begin
            count_next = q_count + CW'(q_wr) - CW'(q_rd);
        end
    end

    // Credit: queued words plus the one returning next cycle must leave a slot.
    assign credit_sum = {1'b0, count_next} + (CW+1)'(req_r & ~redirect_valid);
    assign credit_ok  = (credit_sum < (CW+1)'(DEPTH));

    // PC sequencing, request strobe and outstanding-return tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            req_r      <= 1'b0;
            inflight_r <= 1'b0;
            squash_r   <= 1'b0;
            ret_pc_r   <= {XLEN{1'b0}};
        end else begin
            req_r      <= credit_ok;
            inflight_r <= req_r;
            squash_r   <= req_r & redirect_valid;
            if (req_r) begin
                ret_pc_r <= pc_r;
            end
            if (redirect_valid) begin
                pc_r <= align_pc(redirect_pc);
            end else if (req_r) begin
                pc_r <= pc_r + XLEN'(4);
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr      (q_wr),
        .wr_data (ret_entry),
        .rd      (q_rd),
        .rd_data (head),
        .count   (q_count),
        .empty   (q_empty)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, stall/drain, redirects,
// mid-stream reset. Expected latencies follow IFQ_BYPASS_EN.
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam int LAT_FIRST = 1;
    localparam int LAT_REDIR = 2;
`else
    localparam int LAT_FIRST = 2;
    localparam int LAT_REDIR = 3;
`endif

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic [31:0] mem [256];
    logic [31:0] exp_pc;
    int          n_total;
    int          n_pass;
    int          hs_count;
    int          lat;
    int          hs_before;

    instr_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_word     (instr_word),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: addi x1, x0, <word index>.
    function automatic logic [31:0] mword(input logic [31:0] pc);
        return {pc[13:2], 20'h00093};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = mword(32'(i) << 2);
        end
        imem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive this cycle's inputs, score any handshake, advance to next cycle.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (instr_valid && instr_ready) begin
            check_val("stream_pc", instr_pc, exp_pc);
            check_val("stream_word", instr_word, mword(exp_pc));
            exp_pc = exp_pc + 32'd4;
            hs_count++;
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic rdy);
        while (!instr_valid && lat < 20) begin
            step(rdy, 1'b0, 32'h0);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_total = 0; n_pass = 0; hs_count = 0; exp_pc = 32'h0;
        rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req", {31'h0, imem_req}, 32'h0);
        check_val("rst_addr", {24'h0, imem_addr}, 32'h0);
        check_val("rst_valid", {31'h0, instr_valid}, 32'h0);
        check_val("rst_word", instr_word, 32'h00000013);
        check_val("rst_pc", instr_pc, 32'h0);

        // Stream from reset with ready held high.
        instr_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("c0_req", {31'h0, imem_req}, 32'h1);
        check_val("c0_addr", {24'h0, imem_addr}, 32'h0);
        lat = 0;
        wait_valid(1'b1);
        check_val("first_lat", 32'(lat), 32'(LAT_FIRST));
        check_val("first_pc", instr_pc, 32'h0);
        hs_before = hs_count;
        repeat (10) step(1'b1, 1'b0, 32'h0);
        check_val("stream_rate", 32'(hs_count - hs_before), 32'd10);

        // Stall: queue fills to DEPTH and fetching stops.
        repeat (10) step(1'b0, 1'b0, 32'h0);
        check_val("stall_req", {31'h0, imem_req}, 32'h0);
        check_val("stall_count", 32'(dut.u_fifo.count), 32'd4);
        check_val("stall_valid", {31'h0, instr_valid}, 32'h1);
        hs_before = hs_count;
        repeat (12) step(1'b1, 1'b0, 32'h0);
        check_val("drain_rate", 32'(hs_count - hs_before), 32'd12);

        // Reset with a request outstanding: outputs clear at once.
        check_val("pre_rst_req", {31'h0, imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check_val("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        check_val("mid_rst_word", instr_word, 32'h00000013);
        check_val("mid_rst_pc", instr_pc, 32'h0);
        check_val("mid_rst_addr", {24'h0, imem_addr}, 32'h0);
        check_val("mid_rst_infl", {31'h0, dut.inflight_r}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        instr_ready = 1'b0;
        rst = 1'b0;
        exp_pc = 32'h0;
        step(1'b0, 1'b0, 32'h0);
        check_val("restart_req", {31'h0, imem_req}, 32'h1);
        check_val("restart_addr", {24'h0, imem_addr}, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check_val("c4_count", 32'(dut.u_fifo.count), 32'd3);
        check_val("c4_infl", {31'h0, dut.inflight_r}, 32'h1);

        // Redirect to 0x40 with three queued and one returning.
        step(1'b0, 1'b1, 32'h40);
        check_val("rd_req", {31'h0, imem_req}, 32'h1);
        check_val("rd_addr", {24'h0, imem_addr}, 32'h10);
        check_val("rd_valid", {31'h0, instr_valid}, 32'h0);
        lat = 1;
        wait_valid(1'b1);
        check_val("rd_lat", 32'(lat), 32'(LAT_REDIR));
        check_val("rd_pc", instr_pc, 32'h40);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects, last (unaligned) one wins.
        step(1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b1, 32'h43);
        check_val("b2b_req", {31'h0, imem_req}, 32'h1);
        check_val("b2b_addr", {24'h0, imem_addr}, 32'h10);
        lat = 1;
        wait_valid(1'b1);
        check_val("b2b_lat", 32'(lat), 32'(LAT_REDIR));
        check_val("b2b_pc", instr_pc, 32'h40);
        check_val("b2b_word", instr_word, 32'h01000093);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
